// File: rtl/cafetera_pkg.sv
// Shared constants for the coffee machine payout path: FSM encodings and coin denominations.
// Money is counted in units of 50 colones throughout.
package cafetera_pkg;

    typedef logic [2:0] estado_t;

    localparam estado_t ST_IDLE     = 3'd0;
    localparam estado_t ST_CHECK    = 3'd1;
    localparam estado_t ST_DISPENSE = 3'd2;
    localparam estado_t ST_PICK     = 3'd3;
    localparam estado_t ST_WAIT_ACK = 3'd4;
    localparam estado_t ST_FINISH   = 3'd5;
    localparam estado_t ST_FAULT    = 3'd6;

    localparam logic [1:0] MONEDA_50  = 2'd0;
    localparam logic [1:0] MONEDA_100 = 2'd1;
    localparam logic [1:0] MONEDA_200 = 2'd2;
    localparam logic [1:0] MONEDA_500 = 2'd3;

    // Indexed by coin_type: 1, 2, 4 and 10 units.
    localparam logic [3:0][3:0] VALOR_MONEDA = {4'd10, 4'd4, 4'd2, 4'd1};

endpackage

// File: rtl/cafetera_selector_moneda.sv
// Greedy coin picker: largest available denomination that still fits in the remaining change.
// Purely combinational; valid is low when no stocked coin fits.
module cafetera_selector_moneda
    import cafetera_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] remaining,
    input  logic [3:0]   hopper_empty,
    output logic [1:0]   coin_type,
    output logic         valid
);

    always_comb begin
        coin_type = MONEDA_50;
        valid     = 1'b0;
        // Ascending scan so the largest qualifying denomination overwrites smaller ones.
        for (int i = 0; i < 4; i++) begin
            if (!hopper_empty[i] && (W'(VALOR_MONEDA[i]) <= remaining)) begin
                coin_type = 2'(i);
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cafetera_cambio.sv
// Payout controller: checks credit against price, drives the drink valve, then pays change
// coin by coin through the hopper req/ack handshake; a hopper timeout or empty stock latches FAULT.
module cafetera_cambio
    import cafetera_pkg::*;
#(
    parameter int W           = 8,
    parameter int DISP_CYCLES = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] credito,
    input  logic [W-1:0] precio,
    input  logic [3:0]   hopper_empty,
    input  logic         coin_ack,
    output logic         coin_req,
    output logic [1:0]   coin_type,
    output logic         dispense_en,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic         fault,
    output logic [W-1:0] cambio_restante
);

    localparam int DW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    estado_t        state;
    logic [W-1:0]   cred_q;
    logic [W-1:0]   prec_q;
    logic [W-1:0]   rem_q;
    logic [1:0]     coin_type_q;
    logic [DW-1:0]  disp_cnt;
    logic [TW-1:0]  to_cnt;

    logic           pago_ok;
    logic [W-1:0]   check_rem;
    logic [1:0]     sel_type;
    logic           sel_valid;

    assign pago_ok   = (cred_q >= prec_q);
    assign check_rem = pago_ok ? (cred_q - prec_q) : cred_q;

    cafetera_selector_moneda #(.W(W)) u_selector (
        .remaining    (rem_q),
        .hopper_empty (hopper_empty),
        .coin_type    (sel_type),
        .valid        (sel_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cred_q      <= '0;
            prec_q      <= '0;
            rem_q       <= '0;
            coin_type_q <= MONEDA_50;
            disp_cnt    <= '0;
            to_cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cred_q <= credito;
                        prec_q <= precio;
                        state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    rem_q <= check_rem;
                    if (pago_ok) begin
                        disp_cnt <= '0;
                        state    <= ST_DISPENSE;
                    end else begin
                        state <= ST_PICK;
                    end
                end
                ST_DISPENSE: begin
                    if (disp_cnt == DW'(DISP_CYCLES - 1)) begin
                        state <= ST_PICK;
                    end else begin
                        disp_cnt <= disp_cnt + 1'b1;
                    end
                end
                ST_PICK: begin
                    if (rem_q == '0) begin
                        state <= ST_FINISH;
                    end else if (sel_valid) begin
                        coin_type_q <= sel_type;
                        to_cnt      <= '0;
                        state       <= ST_WAIT_ACK;
                    end else begin
                        state <= ST_FAULT;
                    end
                end
                ST_WAIT_ACK: begin
                    // An ack arriving on the last allowed cycle still counts.
                    if (coin_ack) begin
                        rem_q <= rem_q - W'(VALOR_MONEDA[coin_type_q]);
                        state <= ST_PICK;
                    end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
                        state <= ST_FAULT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                ST_FAULT:  state <= ST_FAULT;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode the state register directly so reset clears them without a clock edge.
    assign coin_req        = (state == ST_WAIT_ACK);
    assign coin_type       = coin_type_q;
    assign dispense_en     = (state == ST_DISPENSE);
    assign busy            = (state != ST_IDLE) && (state != ST_FAULT);
    assign done            = (state == ST_FINISH);
    assign error           = (state == ST_CHECK) && !pago_ok;
    assign fault           = (state == ST_FAULT);
    assign cambio_restante = (state == ST_CHECK) ? check_rem : rem_q;

endmodule

// File: tb/tb_cafetera_cambio.sv
// Bench for cafetera_cambio: a coin scoreboard checks each hopper request against the expected
// denomination and remaining change; per-transaction counters check dispense, error and done.
module tb_cafetera_cambio;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] credito;
    logic [7:0] precio;
    logic [3:0] hopper_empty;
    logic       coin_ack;
    logic       coin_req;
    logic [1:0] coin_type;
    logic       dispense_en;
    logic       busy;
    logic       done;
    logic       error;
    logic       fault;
    logic [7:0] cambio_restante;

    always #5 clk = ~clk;

    cafetera_cambio #(.W(8), .DISP_CYCLES(4), .ACK_TIMEOUT(255)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .credito         (credito),
        .precio          (precio),
        .hopper_empty    (hopper_empty),
        .coin_ack        (coin_ack),
        .coin_req        (coin_req),
        .coin_type       (coin_type),
        .dispense_en     (dispense_en),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .fault           (fault),
        .cambio_restante (cambio_restante)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [1:0] tipo;
        logic [7:0] cambio;
    } coin_exp_t;

    coin_exp_t exp_q[$];

    function automatic coin_exp_t mk(input logic [1:0] t, input logic [7:0] c);
        coin_exp_t e;
        e.tipo   = t;
        e.cambio = c;
        return e;
    endfunction

    // Monitor: event counters plus scoreboard pop on every new coin request.
    int   n_disp = 0, n_err = 0, n_done = 0, n_req = 0;
    int   req_run = 0, last_run = 0;
    logic req_prev = 1'b0;

    always @(negedge clk) begin
        if (dispense_en) n_disp <= n_disp + 1;
        if (error)       n_err  <= n_err + 1;
        if (done)        n_done <= n_done + 1;
        if (coin_req) begin
            req_run <= req_run + 1;
        end else begin
            if (req_run != 0) last_run <= req_run;
            req_run <= 0;
        end
        if (coin_req && !req_prev) begin
            n_req <= n_req + 1;
            if (exp_q.size() == 0) begin
                check_val("coin_unexpected", 32'(coin_type), 32'hFFFF_FFFF);
            end else begin
                check_val("coin_type", 32'(coin_type), 32'(exp_q[0].tipo));
                check_val("coin_cambio", 32'(cambio_restante), 32'(exp_q[0].cambio));
                void'(exp_q.pop_front());
            end
        end
        req_prev <= coin_req;
    end

    // Hopper model: acks a request after ack_delay observed cycles when enabled.
    logic ack_en = 1'b1;
    int   ack_delay = 2;

    initial begin
        int cnt;
        cnt = 0;
        coin_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_en && coin_req) begin
                cnt++;
                coin_ack = (cnt >= ack_delay);
            end else begin
                cnt = 0;
                coin_ack = 1'b0;
            end
        end
    end

    task automatic pulse_start(input logic [7:0] c, input logic [7:0] p);
        @(negedge clk);
        start   = 1'b1;
        credito = c;
        precio  = p;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_txn(input string nm, input logic [7:0] c, input logic [7:0] p,
                           input logic [3:0] he, input logic exp_err, input logic [7:0] exp_rem);
        int         d0, e0, k0, r0, exp_coins;
        logic [6:0] patt;
        logic       got;
        d0 = n_disp; e0 = n_err; k0 = n_done; r0 = n_req;
        exp_coins = exp_q.size();
        hopper_empty = he;
        patt = '0;
        pulse_start(c, p);
        check_val({nm, "_check_error"}, 32'(error), 32'(exp_err));
        check_val({nm, "_check_cambio"}, 32'(cambio_restante), 32'(exp_rem));
        patt[1] = dispense_en;
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            patt[k] = dispense_en;
        end
        check_val({nm, "_disp_window"}, 32'(patt), exp_err ? 32'd0 : 32'b0111100);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            if (done) got = 1'b1;
            else @(negedge clk);
        end
        check_val({nm, "_done_seen"}, 32'(got), 32'd1);
        @(negedge clk);
        check_val({nm, "_done_pulse"}, 32'(done), 32'd0);
        check_val({nm, "_idle"}, 32'(busy), 32'd0);
        check_val({nm, "_cambio_end"}, 32'(cambio_restante), 32'd0);
        check_val({nm, "_coins_left"}, 32'(exp_q.size()), 32'd0);
        check_val({nm, "_n_req"}, 32'(n_req - r0), 32'(exp_coins));
        check_val({nm, "_n_done"}, 32'(n_done - k0), 32'd1);
        check_val({nm, "_n_err"}, 32'(n_err - e0), 32'(exp_err));
        check_val({nm, "_n_disp"}, 32'(n_disp - d0), exp_err ? 32'd0 : 32'd4);
    endtask

    initial begin
        int   d0;
        logic got;
        rst_n = 1'b0;
        start = 1'b0;
        credito = '0;
        precio = '0;
        hopper_empty = '0;
        repeat (3) @(negedge clk);
        check_val("rst_outputs", 32'({coin_req, dispense_en, busy, done, error, fault}), 32'd0);
        check_val("rst_cambio", 32'(cambio_restante), 32'd0);
        check_val("rst_coin_type", 32'(coin_type), 32'd0);
        rst_n = 1'b1;

        exp_q.push_back(mk(2'd2, 8'd5));
        exp_q.push_back(mk(2'd0, 8'd1));
        run_txn("c12p7", 8'd12, 8'd7, 4'b0000, 1'b0, 8'd5);

        run_txn("c7p7", 8'd7, 8'd7, 4'b0000, 1'b0, 8'd0);

        exp_q.push_back(mk(2'd1, 8'd3));
        exp_q.push_back(mk(2'd0, 8'd1));
        run_txn("c3p7", 8'd3, 8'd7, 4'b0000, 1'b1, 8'd3);

        exp_q.push_back(mk(2'd1, 8'd6));
        exp_q.push_back(mk(2'd1, 8'd4));
        exp_q.push_back(mk(2'd1, 8'd2));
        run_txn("c16p10", 8'd16, 8'd10, 4'b0100, 1'b0, 8'd6);

        run_txn("c0p0", 8'd0, 8'd0, 4'b0000, 1'b0, 8'd0);

        // Hopper never answers: timeout into FAULT.
        ack_en = 1'b0;
        hopper_empty = 4'b0000;
        exp_q.push_back(mk(2'd1, 8'd2));
        pulse_start(8'd9, 8'd7);
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            if (fault) got = 1'b1;
            else @(negedge clk);
        end
        check_val("to_fault_seen", 32'(got), 32'd1);
        @(negedge clk);
        check_val("to_req_len", 32'(last_run), 32'd255);
        check_val("to_req_low", 32'(coin_req), 32'd0);
        check_val("to_busy", 32'(busy), 32'd0);
        check_val("to_cambio", 32'(cambio_restante), 32'd2);
        d0 = n_disp;
        pulse_start(8'd20, 8'd1);
        repeat (10) @(negedge clk);
        check_val("to_start_ignored_fault", 32'(fault), 32'd1);
        check_val("to_start_ignored_busy", 32'(busy), 32'd0);
        check_val("to_start_ignored_disp", 32'(n_disp - d0), 32'd0);
        check_val("to_cambio_hold", 32'(cambio_restante), 32'd2);

        rst_n = 1'b0;
        @(negedge clk);
        check_val("fault_cleared", 32'(fault), 32'd0);
        rst_n = 1'b1;

        // Asynchronous reset while waiting on the hopper.
        exp_q.push_back(mk(2'd1, 8'd2));
        pulse_start(8'd9, 8'd7);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (coin_req) got = 1'b1;
            else @(negedge clk);
        end
        check_val("ar_req_seen", 32'(got), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("ar_coin_req", 32'(coin_req), 32'd0);
        check_val("ar_busy", 32'(busy), 32'd0);
        check_val("ar_cambio", 32'(cambio_restante), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_en = 1'b1;
        run_txn("c4p4", 8'd4, 8'd4, 4'b0000, 1'b0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cafetera_cambio.md
Name: cafetera_cambio

Overview:
- Payout end of the coffee machine's coin path.
- The coin intake side accumulates credit. This block takes the latched credit and the selected drink price, fires the dispense valve, and returns change through a coin hopper with a req/ack handshake.
- It sits between the selection/credit logic and the physical hopper/valve drivers.
- It exports status for the 7-segment mux: remaining change, busy, and error/fault.

Parameters:
- W, 8, width of all money quantities, in units of 50 colones.
- DISP_CYCLES, 4, number of cycles dispense_en stays high.
- ACK_TIMEOUT, 255, maximum cycles to wait for coin_ack before a fault.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- start  in  1  one-cycle purchase request; sampled only in IDLE
- credito  in  W  accumulated credit; sampled with start
- precio  in  W  price of the selected drink; sampled with start
- hopper_empty  in  4  per-denomination empty flags; bit i means denomination i is unavailable
- coin_ack  in  1  hopper has ejected the requested coin
- coin_req  out  1  request ejection of one coin
- coin_type  out  2  denomination index: 0=1u (50), 1=2u (100), 2=4u (200), 3=10u (500)
- dispense_en  out  1  drink valve drive
- busy  out  1  high in any state other than IDLE and FAULT
- done  out  1  one-cycle pulse when a transaction completes
- error  out  1  one-cycle pulse at CHECK when credito < precio
- fault  out  1  level; high in FAULT
- cambio_restante  out  W  change still to be paid, for the display

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, including cambio_restante. All counters cleared. Reset mid-transaction aborts immediately: coin_req and dispense_en drop asynchronously, and no partial state survives.
- States: IDLE, CHECK, DISPENSE, PICK, WAIT_ACK, FINISH, FAULT.
- IDLE:
  - start=1 latches credito and precio, then goes to CHECK on the next cycle.
  - start while not in IDLE is ignored.
- CHECK (1 cycle):
  - If credito >= precio: remaining = credito - precio, go to DISPENSE.
  - Otherwise: remaining = credito (full refund), pulse error, go to PICK with no dispense.
  - cambio_restante tracks remaining from this cycle on.
- DISPENSE:
  - dispense_en is high for exactly DISP_CYCLES consecutive cycles.
  - With start at cycle 0, dispense_en is high in cycles 2 through 2+DISP_CYCLES-1.
  - Then go to PICK.
- PICK (1 cycle):
  - If remaining = 0, go to FINISH.
  - Otherwise choose the largest denomination d with value(d) <= remaining and hopper_empty[d]=0 (greedy), register it on coin_type, and go to WAIT_ACK.
  - If no denomination qualifies while remaining > 0, go to FAULT.
- WAIT_ACK:
  - coin_req=1; coin_type is held stable.
  - coin_ack=1 is accepted in the same cycle: remaining -= value(coin_type), coin_req drops next cycle, return to PICK.
  - The timeout counter increments every cycle. Reaching ACK_TIMEOUT without ack goes to FAULT.
  - coin_ack while coin_req=0 is ignored.
- FINISH (1 cycle): pulse done, go to IDLE.
- FAULT:
  - fault=1, coin_req=0, dispense_en=0.
  - cambio_restante holds the unpaid amount.
  - Exit only via rst_n.
- Arithmetic: unsigned W-bit throughout. The subtraction never underflows by construction (greedy fit). Denomination values are zero-extended to W.
- Edge cases:
  - credito = precio: no coin_req ever asserted; done follows dispense.
  - credito = precio = 0: still dispenses.
  - hopper_empty changes mid-transaction: sampled only in PICK.
  - Simultaneous coin_ack and timeout expiry: ack wins.

Decomposition:
- Package cafetera_pkg: state enum, coin index constants (MONEDA_50/100/200/500), denomination value array {1,2,4,10}.
- Sub-module cafetera_selector_moneda: combinational greedy picker.
  - Inputs: remaining, hopper_empty.
  - Outputs: coin_type, valid.

Test Plan:
- credito=12, precio=7, hopper full, ack 2 cycles after each req → dispense_en 4 cycles; coins type 2 then type 0; cambio_restante 5→1→0; one done pulse; error never set.
- credito=7, precio=7 → dispense 4 cycles, zero coin_req, done pulse, cambio_restante 0.
- credito=3, precio=7 → error pulse at CHECK, dispense_en never high, coins type 1 then type 0, done pulse.
- credito=16, precio=10, hopper_empty=4'b0100 → change 6 paid as type 1, 1, 1; no type 2 request.
- credito=9, precio=7, coin_ack never asserted → coin_req high exactly ACK_TIMEOUT cycles, then fault=1, coin_req=0, cambio_restante=2; a later start is ignored.
- rst_n pulled low during WAIT_ACK → coin_req, busy, and cambio_restante go to 0 without waiting for a clock edge; after release, credito=4, precio=4 completes normally.
